// File: rtl/flash_read_sequencer.sv
// Flash-to-audio read sequencer: fetches one 32-bit flash word per two sample ticks
// and plays its two 16-bit halves in the order fixed by the direction captured at fetch.
module flash_read_sequencer #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              canReadFlash,
  input  logic              isFwrd,
  input  logic              restartKey,
  output logic              readDone,
  output logic              flash_mem_read,
  input  logic              flash_mem_waitrequest,
  input  logic              flash_mem_readdatavalid,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic [31:0]       flash_mem_readdata,
  output logic [3:0]        flash_mem_byteenable,
  output logic [15:0]       audio_out,
  output logic              audio_valid
);

  typedef enum logic [2:0] {
    WAIT_TICK  = 3'd0,
    REQ        = 3'd1,
    WAIT_VALID = 3'd2,
    OUT_FIRST  = 3'd3,
    WAIT_TICK2 = 3'd4,
    OUT_SECOND = 3'd5,
    ADVANCE    = 3'd6,
    RESTART    = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [15:0]       audio_q, audio_d;
  logic              valid_q, valid_d;
  logic              dir_q, dir_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_TICK;
      addr_q  <= '0;
      word_q  <= '0;
      audio_q <= 16'h0000;
      valid_q <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      audio_q <= audio_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    audio_d = audio_q;
    valid_d = 1'b0;
    dir_d   = dir_q;
    case (state_q)
      WAIT_TICK: begin
        if (restartKey) begin
          state_d = RESTART;
        end else if (sample_tick && canReadFlash) begin
          dir_d   = isFwrd;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!flash_mem_waitrequest) state_d = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (flash_mem_readdatavalid) begin
          word_d  = flash_mem_readdata;
          state_d = OUT_FIRST;
        end
      end
      OUT_FIRST: begin
        audio_d = dir_q ? word_q[15:0] : word_q[31:16];
        valid_d = 1'b1;
        state_d = WAIT_TICK2;
      end
      WAIT_TICK2: begin
        // A restart here drops the unplayed half of the current word.
        if (restartKey) begin
          state_d = RESTART;
        end else if (sample_tick && canReadFlash) begin
          state_d = OUT_SECOND;
        end
      end
      OUT_SECOND: begin
        audio_d = dir_q ? word_q[31:16] : word_q[15:0];
        valid_d = 1'b1;
        state_d = ADVANCE;
      end
      ADVANCE: begin
        // Step direction follows the live isFwrd, not the value captured at fetch.
        if (isFwrd) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        else        addr_d = (addr_q == '0) ? LAST_ADDR : addr_q - ADDR_W'(1);
        state_d = WAIT_TICK;
      end
      RESTART: begin
        addr_d  = isFwrd ? '0 : LAST_ADDR;
        state_d = WAIT_TICK;
      end
      default: state_d = WAIT_TICK;
    endcase
  end

  // Decoded straight from the state register so both drop the instant reset asserts.
  assign flash_mem_read       = (state_q == REQ);
  assign readDone             = (state_q == RESTART);
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = 4'hF;
  assign audio_out            = audio_q;
  assign audio_valid          = valid_q;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Directed bench for flash_read_sequencer: the bench plays the flash slave and
// checks sample order, address stepping/wrap, restart, pause and reset behaviour.
module tb_flash_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        canReadFlash;
  logic        isFwrd;
  logic        restartKey;
  logic        readDone;
  logic        flash_mem_read;
  logic        flash_mem_waitrequest;
  logic        flash_mem_readdatavalid;
  logic [22:0] flash_mem_address;
  logic [31:0] flash_mem_readdata;
  logic [3:0]  flash_mem_byteenable;
  logic [15:0] audio_out;
  logic        audio_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flash_read_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .sample_tick             (sample_tick),
    .canReadFlash            (canReadFlash),
    .isFwrd                  (isFwrd),
    .restartKey              (restartKey),
    .readDone                (readDone),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .audio_out               (audio_out),
    .audio_valid             (audio_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for an audio_valid pulse, checks the sample and that the pulse is one cycle.
  task automatic wait_sample(input string tag, input logic [15:0] exp);
    int n = 0;
    while (audio_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, audio_valid, 1);
    chk({tag, "_out"}, audio_out, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, audio_valid, 0);
    chk({tag, "_hold"}, audio_out, exp);
  endtask

  task automatic fetch_first(input string tag, input logic fwd, input int wait_n, input int lat,
                             input logic [31:0] data, input logic [22:0] exp_addr,
                             input logic [15:0] exp_out);
    int rd_cnt = 0;
    isFwrd      = fwd;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int i = 0; i <= wait_n; i++) begin
      flash_mem_waitrequest = (i < wait_n);
      if (flash_mem_read) rd_cnt++;
      chk({tag, "_addr"}, flash_mem_address, exp_addr);
      @(negedge clk);
    end
    flash_mem_waitrequest = 1'b0;
    chk({tag, "_rdcnt"}, rd_cnt, wait_n + 1);
    chk({tag, "_rdoff"}, flash_mem_read, 0);
    repeat (lat - 1) @(negedge clk);
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = data;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = 32'h0BAD_F00D;
    wait_sample({tag, "_s1"}, exp_out);
  endtask

  task automatic play_second(input string tag, input logic [15:0] exp_out, input logic [22:0] exp_addr);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    wait_sample({tag, "_s2"}, exp_out);
    chk({tag, "_next"}, flash_mem_address, exp_addr);
  endtask

  task automatic do_restart(input string tag, input logic fwd, input logic [22:0] exp_addr);
    isFwrd     = fwd;
    restartKey = 1'b1;
    @(negedge clk);
    chk({tag, "_done"}, readDone, 1);
    chk({tag, "_novld"}, audio_valid, 0);
    restartKey = 1'b0;
    @(negedge clk);
    chk({tag, "_done1"}, readDone, 0);
    chk({tag, "_novld1"}, audio_valid, 0);
    chk({tag, "_addr"}, flash_mem_address, exp_addr);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_quiet"}, audio_valid, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int          vld_seen;
    reset = 1'b1; sample_tick = 1'b0; canReadFlash = 1'b0; isFwrd = 1'b1; restartKey = 1'b0;
    flash_mem_waitrequest = 1'b0; flash_mem_readdatavalid = 1'b0; flash_mem_readdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_read", flash_mem_read, 0);
    chk("rst_addr", flash_mem_address, 0);
    chk("rst_out", audio_out, 16'h0000);
    chk("rst_vld", audio_valid, 0);
    chk("rst_done", readDone, 0);
    chk("rst_be", flash_mem_byteenable, 4'hF);
    reset = 1'b0;
    canReadFlash = 1'b1;
    @(negedge clk);

    fetch_first("t1", 1'b1, 0, 2, 32'hBBBB_AAAA, 23'd0, 16'hAAAA);
    play_second("t1", 16'hBBBB, 23'd1);

    for (int a = 1; a < 5; a++) begin
      fetch_first("walk5", 1'b1, 0, 1, 32'h1234_5678, 23'(a), 16'h5678);
      play_second("walk5", 16'h1234, 23'(a + 1));
    end
    fetch_first("t2", 1'b0, 0, 2, 32'h2222_1111, 23'd5, 16'h2222);
    play_second("t2", 16'h1111, 23'd4);
    do_restart("t2rs", 1'b1, 23'd0);
    fetch_first("t2w", 1'b0, 1, 1, 32'h4444_3333, 23'd0, 16'h4444);
    play_second("t2w", 16'h3333, 23'h7FFFF);

    fetch_first("t3", 1'b1, 4, 3, 32'h9999_8888, 23'h7FFFF, 16'h8888);
    play_second("t3", 16'h9999, 23'd0);

    for (int a = 0; a < 100; a++) begin
      fetch_first("walk100", 1'b1, 0, 1, 32'hCAFE_0000 | 32'(a), 23'(a), 16'(a));
      play_second("walk100", 16'hCAFE, 23'(a + 1));
    end
    fetch_first("t4", 1'b1, 0, 2, 32'h7777_6666, 23'd100, 16'h6666);
    do_restart("t4f", 1'b1, 23'd0);
    chk("t4f_out", audio_out, 16'h6666);
    fetch_first("t4b", 1'b1, 0, 2, 32'hEEEE_DDDD, 23'd0, 16'hDDDD);
    do_restart("t4b", 1'b0, 23'h7FFFF);

    fetch_first("t5", 1'b0, 0, 2, 32'h5555_6666, 23'h7FFFF, 16'h5555);
    canReadFlash = 1'b0;
    held = audio_out;
    vld_seen = 0;
    repeat (3) begin
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (4) begin
        if (audio_valid) vld_seen++;
        @(negedge clk);
      end
    end
    chk("t5_novld", vld_seen, 0);
    chk("t5_held", audio_out, held);
    canReadFlash = 1'b1;
    play_second("t5", 16'h6666, 23'h7FFFE);

    isFwrd = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    chk("t6_inwait", flash_mem_read, 0);
    reset = 1'b1;
    #1;
    chk("t6_read", flash_mem_read, 0);
    chk("t6_out", audio_out, 16'h0000);
    chk("t6_addr", flash_mem_address, 0);
    @(negedge clk);
    reset = 1'b0;
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata = 32'hFACE_FACE;
    @(negedge clk);
    flash_mem_readdatavalid = 1'b0;
    vld_seen = 0;
    repeat (5) begin
      if (audio_valid) vld_seen++;
      @(negedge clk);
    end
    chk("t6_stray", vld_seen, 0);
    chk("t6_stray_out", audio_out, 16'h0000);

    flash_mem_waitrequest = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("t6_req", flash_mem_read, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_drop", flash_mem_read, 0);
    @(negedge clk);
    reset = 1'b0;
    flash_mem_waitrequest = 1'b0;
    @(negedge clk);
    chk("t6_idle", flash_mem_read, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_read_sequencer.md
Name: flash_read_sequencer

Overview:
Sequences 32-bit word reads from the on-board flash over its Avalon-MM read port and emits one 16-bit audio sample per audio-rate tick. It is driven by the keyboard control FSM's canReadFlash, isFwrd and restartKey outputs, and returns readDone to that FSM. Each flash word holds two samples. Playback runs forward or backward and wraps at the ends of the sample region. It sits between the keyboard control FSM, the flash controller and the audio output path.

Parameters:
ADDR_W, 23, width of the flash word address.
LAST_ADDR, 23'h7FFFF, highest word address of the sample region.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_tick  in  1  single-cycle pulse at the audio sample rate, synchronous to clk
canReadFlash  in  1  playback enabled (from kbd FSM)
isFwrd  in  1  1 = forward, 0 = backward (from kbd FSM)
restartKey  in  1  restart requested (from kbd FSM)
readDone  out  1  one-cycle pulse: restart processed
flash_mem_read  out  1  Avalon read request
flash_mem_waitrequest  in  1  Avalon wait request
flash_mem_readdatavalid  in  1  Avalon read data valid
flash_mem_address  out  ADDR_W  word address
flash_mem_readdata  in  32  read data
flash_mem_byteenable  out  4  constant 4'hF
audio_out  out  16  current sample, held between updates
audio_valid  out  1  one-cycle pulse when audio_out updates

Behaviour:
- One clock. Reset is asynchronous, active-high, and named reset. Clock is named clk.
- Reset values:
  - state = WAIT_TICK
  - addr = 0, flash_mem_address = 0
  - flash_mem_read = 0, readDone = 0
  - audio_out = 16'h0000, audio_valid = 0
  - latched word = 0, dir_l = 1
- flash_mem_address is always driven from the addr register.
- States:
  - WAIT_TICK:
    - If restartKey = 1, go to RESTART. This has priority over the tick.
    - Else if sample_tick & canReadFlash, set dir_l <= isFwrd and go to REQ.
    - Else stay.
  - REQ:
    - flash_mem_read = 1, address stable.
    - Stay while waitrequest = 1.
    - On the cycle waitrequest = 0, go to WAIT_VALID. flash_mem_read is 0 from the next cycle.
  - WAIT_VALID:
    - On readdatavalid, latch readdata and go to OUT_FIRST.
    - No timeout.
  - OUT_FIRST:
    - audio_out <= dir_l ? word[15:0] : word[31:16].
    - audio_valid = 1 for this one cycle.
    - Go to WAIT_TICK2.
  - WAIT_TICK2:
    - If restartKey = 1, go to RESTART. The second half is discarded.
    - Else if sample_tick & canReadFlash, go to OUT_SECOND.
    - Else stay (paused; audio_out held).
  - OUT_SECOND:
    - audio_out <= dir_l ? word[31:16] : word[15:0].
    - audio_valid = 1 for this one cycle.
    - Go to ADVANCE.
  - ADVANCE:
    - If isFwrd (sampled now): addr <= (addr == LAST_ADDR) ? 0 : addr + 1.
    - Else: addr <= (addr == 0) ? LAST_ADDR : addr − 1.
    - Go to WAIT_TICK.
  - RESTART:
    - addr <= isFwrd ? 0 : LAST_ADDR.
    - readDone = 1 for this one cycle.
    - Go to WAIT_TICK.
- Latencies:
  - Tick-to-first-sample = 1 (REQ, zero wait) + Avalon latency + 1 cycles.
  - Second sample follows 1 cycle after the next accepted tick.
- Pause: canReadFlash = 0 is honoured only in WAIT_TICK and WAIT_TICK2. A fetch already in flight completes, and its first sample is still emitted.
- restartKey in REQ, WAIT_VALID, OUT_* or ADVANCE is acted on at the next WAIT_TICK or WAIT_TICK2. An Avalon transaction is never abandoned.
- sample_tick arriving outside WAIT_TICK and WAIT_TICK2 is dropped. The system requires tick period > worst-case fetch latency + 3 cycles.
- Direction change mid-word: half ordering uses dir_l, the value captured at fetch. The address step uses isFwrd at ADVANCE.
- readDone is combinational from state == RESTART only. The kbd FSM leaves its restart state on that edge, so restartKey is 0 on re-entering WAIT_TICK.
- Reset mid-transaction: everything returns to reset values immediately, and flash_mem_read drops asynchronously.
- Unused/illegal state encodings go to WAIT_TICK.

Test Plan:
1. Reset, then canReadFlash = 1, isFwrd = 1, flash word at addr 0 = 32'hBBBB_AAAA, waitrequest low 1 cycle, readdatavalid 2 cycles later, two ticks -> audio_out = 16'hAAAA then 16'hBBBB, each with a single audio_valid pulse; addr = 1.
2. isFwrd = 0, addr = 5, word 32'h2222_1111, two ticks -> audio_out = 16'h2222 then 16'h1111; addr = 4. Repeat from addr = 0 -> addr wraps to 23'h7FFFF.
3. Forward at addr = 23'h7FFFF, two ticks -> addr = 0. waitrequest held high 4 cycles -> flash_mem_read stays high exactly those cycles plus 1; address stable throughout.
4. restartKey = 1 with isFwrd = 1 in WAIT_TICK2, addr = 100 -> second half never emitted; readDone high exactly 1 cycle; addr = 0. Same with isFwrd = 0 -> addr = 23'h7FFFF.
5. canReadFlash = 0 in WAIT_TICK2 with 3 ticks -> no audio_valid and audio_out held. Re-enable, one tick -> second half emitted.
6. Assert reset during WAIT_VALID -> flash_mem_read = 0, audio_out = 0, addr = 0 immediately. A stray readdatavalid afterwards -> no audio_valid.
